// File: rtl/bforge_apb_splitter.sv
// APB 1-to-4 splitter: decodes a 3-bit region field and forwards the transfer to one of four targets.
// Define BFORGE_APB_SPLITTER_TIMEOUT_EN to build in the ACCESS-phase watchdog.

module bforge_apb_splitter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned SEL_LSB        = 12,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic [ADDR_W-1:0]     s_paddr,
    input  logic                  s_pwrite,
    input  logic [DATA_W-1:0]     s_pwdata,
    input  logic [DATA_W/8-1:0]   s_pstrb,
    input  logic [2:0]            s_pprot,
    input  logic                  s_psel,
    input  logic                  s_penable,
    output logic [DATA_W-1:0]     s_prdata,
    output logic                  s_pready,
    output logic                  s_pslverr,
    output logic [ADDR_W-1:0]     m_paddr,
    output logic                  m_pwrite,
    output logic [DATA_W-1:0]     m_pwdata,
    output logic [DATA_W/8-1:0]   m_pstrb,
    output logic [2:0]            m_pprot,
    output logic [3:0]            m_psel,
    output logic                  m_penable,
    input  logic [4*DATA_W-1:0]   m_prdata,
    input  logic [3:0]            m_pready,
    input  logic [3:0]            m_pslverr,
    output logic                  timeout_o
);

    localparam logic [7:0] ToLimit = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;
    logic [DATA_W/8-1:0] r_pstrb;
    logic [2:0]          r_pprot;
    logic [1:0]          r_sel;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_slverr;
    logic [2:0]          w_region;
    logic                w_ready_sel;
    logic                w_slverr_sel;
    logic [DATA_W-1:0]   w_rdata_sel;
    logic                w_expire;
    logic                w_active;
    logic                w_unused;

    assign w_region     = s_paddr[SEL_LSB+2:SEL_LSB];
    assign w_ready_sel  = m_pready[r_sel];
    assign w_slverr_sel = m_pslverr[r_sel];
    // s_penable carries no information the splitter needs; the limit is only consumed by the watchdog.
    assign w_unused     = s_penable ^ ToLimit[0];

    always_comb begin
        w_rdata_sel = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_sel == 2'(i)) w_rdata_sel = m_prdata[i*DATA_W +: DATA_W];
        end
    end

`ifdef BFORGE_APB_SPLITTER_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_timeout;

    // A ready target in the limit cycle still completes normally.
    assign w_expire = (r_state == StAccess) && !w_ready_sel && ((r_cnt + 8'd1) == ToLimit);

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (r_state == StSetup) begin
                r_cnt <= '0;
            end else if ((r_state == StAccess) && !w_ready_sel) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_expire  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (s_psel) w_state_next = w_region[2] ? StResp : StSetup;
            end
            StSetup:  w_state_next = StAccess;
            StAccess: begin
                if (w_ready_sel || w_expire) w_state_next = StResp;
            end
            StResp:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
            r_sel    <= '0;
            r_rdata  <= '0;
            r_slverr <= 1'b0;
        end else begin
            if ((r_state == StIdle) && s_psel) begin
                r_paddr  <= s_paddr;
                r_pwrite <= s_pwrite;
                r_pwdata <= s_pwdata;
                r_pstrb  <= s_pstrb;
                r_pprot  <= s_pprot;
                r_sel    <= w_region[1:0];
                r_rdata  <= '0;
                r_slverr <= w_region[2];
            end else if ((r_state == StAccess) && w_ready_sel) begin
                r_rdata  <= w_rdata_sel;
                r_slverr <= w_slverr_sel;
            end else if (w_expire) begin
                r_rdata  <= '0;
                r_slverr <= 1'b1;
            end
        end
    end

    always_comb begin
        w_active  = (r_state == StSetup) || (r_state == StAccess);
        m_psel    = w_active ? (4'b0001 << r_sel) : 4'b0000;
        m_penable = (r_state == StAccess);
        m_paddr   = w_active ? r_paddr : '0;
        m_pwrite  = w_active ? r_pwrite : 1'b0;
        m_pwdata  = w_active ? r_pwdata : '0;
        m_pstrb   = w_active ? r_pstrb : '0;
        m_pprot   = w_active ? r_pprot : '0;
        s_pready  = (r_state == StResp);
        s_prdata  = s_pready ? r_rdata : '0;
        s_pslverr = s_pready ? r_slverr : 1'b0;
    end

endmodule

// File: tb/tb_bforge_apb_splitter.sv
// Scoreboard bench for bforge_apb_splitter: stimulus queues expected request/response, monitor checks.

module tb_bforge_apb_splitter;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic [31:0]   s_paddr = '0;
    logic          s_pwrite = 1'b0;
    logic [31:0]   s_pwdata = '0;
    logic [3:0]    s_pstrb = '0;
    logic [2:0]    s_pprot = '0;
    logic          s_psel = 1'b0;
    logic          s_penable = 1'b0;
    logic [31:0]   s_prdata;
    logic          s_pready;
    logic          s_pslverr;
    logic [31:0]   m_paddr;
    logic          m_pwrite;
    logic [31:0]   m_pwdata;
    logic [3:0]    m_pstrb;
    logic [2:0]    m_pprot;
    logic [3:0]    m_psel;
    logic          m_penable;
    logic [127:0]  m_prdata;
    logic [3:0]    m_pready = '0;
    logic [3:0]    m_pslverr = '0;
    logic          timeout_o;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        logic        to;
    } rsp_t;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } req_t;

    rsp_t        rsp_q[$];
    req_t        req_q[$];
    rsp_t        mon_rsp;
    req_t        mon_req;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] tgt_data [4];
    int          tgt_wait [4];
    logic [3:0]  tgt_err = 4'b1000;
    logic [3:0]  idle_rdy = 4'b0001;
    logic [3:0]  idle_err = 4'b0001;
    int          acc [4];

    bforge_apb_splitter #(
        .ADDR_W(32),
        .DATA_W(32),
        .SEL_LSB(12),
        .TIMEOUT_CYCLES(16)
    ) u_dut (
        .pclk(pclk),
        .preset(preset),
        .s_paddr(s_paddr),
        .s_pwrite(s_pwrite),
        .s_pwdata(s_pwdata),
        .s_pstrb(s_pstrb),
        .s_pprot(s_pprot),
        .s_psel(s_psel),
        .s_penable(s_penable),
        .s_prdata(s_prdata),
        .s_pready(s_pready),
        .s_pslverr(s_pslverr),
        .m_paddr(m_paddr),
        .m_pwrite(m_pwrite),
        .m_pwdata(m_pwdata),
        .m_pstrb(m_pstrb),
        .m_pprot(m_pprot),
        .m_psel(m_psel),
        .m_penable(m_penable),
        .m_prdata(m_prdata),
        .m_pready(m_pready),
        .m_pslverr(m_pslverr),
        .timeout_o(timeout_o)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    assign m_prdata = {tgt_data[3], tgt_data[2], tgt_data[1], tgt_data[0]};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Target model: selected target becomes ready after tgt_wait ACCESS cycles; idle ones drive idle_*.
    always @(negedge pclk) begin
        for (int i = 0; i < 4; i++) begin
            if (m_psel[i] && m_penable) begin
                m_pready[i]  = (acc[i] == tgt_wait[i]);
                m_pslverr[i] = tgt_err[i];
                acc[i]       = acc[i] + 1;
            end else begin
                acc[i]       = 0;
                m_pready[i]  = idle_rdy[i];
                m_pslverr[i] = idle_err[i];
            end
        end
    end

    always @(negedge pclk) begin
        if (!preset) begin
            if (s_pready) begin
                chk("resp_psel_low", {59'd0, m_psel, m_penable}, 64'd0);
                chk("resp_expected", 64'(rsp_q.size() != 0), 64'd1);
                if (rsp_q.size() != 0) begin
                    mon_rsp = rsp_q.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(mon_rsp.cyc));
                    chk("resp_prdata", 64'(s_prdata), 64'(mon_rsp.rdata));
                    chk("resp_pslverr", 64'(s_pslverr), 64'(mon_rsp.err));
                    chk("resp_timeout", 64'(timeout_o), 64'(mon_rsp.to));
                end
            end else begin
                chk("idle_outputs_zero", {29'd0, s_prdata, s_pslverr, timeout_o}, 64'd0);
            end
            if ((m_psel != 4'b0) && !m_penable) begin
                chk("req_expected", 64'(req_q.size() != 0), 64'd1);
                if (req_q.size() != 0) begin
                    mon_req = req_q.pop_front();
                    chk("req_psel", 64'(m_psel), 64'(mon_req.sel));
                    chk("req_paddr", 64'(m_paddr), 64'(mon_req.addr));
                    chk("req_pwrite", 64'(m_pwrite), 64'(mon_req.wr));
                    chk("req_pwdata", 64'(m_pwdata), 64'(mon_req.wdata));
                    chk("req_pstrb", 64'(m_pstrb), 64'(mon_req.strb));
                    chk("req_pprot", 64'(m_pprot), 64'(mon_req.prot));
                end
            end
        end
    end

    // Called at a negedge; lat is the cycle offset (from now) at which s_pready is expected.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [3:0] exp_sel,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                        input logic hold, input logic exp_to);
        rsp_t e;
        req_t r;
        logic in_resp;
        in_resp   = s_pready;
        s_paddr   = addr;
        s_pwrite  = wr;
        s_pwdata  = wdata;
        s_pstrb   = strb;
        s_pprot   = strb[2:0];
        s_psel    = 1'b1;
        s_penable = 1'b0;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc + lat;
        e.to    = exp_to;
        rsp_q.push_back(e);
        if (exp_sel != 4'b0) begin
            r.sel   = exp_sel;
            r.addr  = addr;
            r.wr    = wr;
            r.wdata = wdata;
            r.strb  = strb;
            r.prot  = strb[2:0];
            req_q.push_back(r);
        end
        @(negedge pclk);
        if (in_resp) @(negedge pclk);
        s_penable = 1'b1;
        if (!hold) begin
            s_psel   = 1'b0;
            s_paddr  = 32'hFFFF_FFFF;
            s_pwdata = 32'h0BAD_0BAD;
        end
        for (int k = 0; k < 100; k++) begin
            if (s_pready) break;
            @(negedge pclk);
        end
        chk("resp_arrived", 64'(s_pready), 64'd1);
        s_penable = 1'b0;
        if (!hold) @(negedge pclk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_m_psel"}, 64'(m_psel), 64'd0);
        chk({tag, "_m_penable"}, 64'(m_penable), 64'd0);
        chk({tag, "_m_paddr"}, 64'(m_paddr), 64'd0);
        chk({tag, "_m_pwdata"}, 64'(m_pwdata), 64'd0);
        chk({tag, "_m_ctrl"}, {56'd0, m_pwrite, m_pstrb, m_pprot}, 64'd0);
        chk({tag, "_s_pready"}, 64'(s_pready), 64'd0);
        chk({tag, "_s_prdata"}, 64'(s_prdata), 64'd0);
        chk({tag, "_s_pslverr"}, 64'(s_pslverr), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout_o), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        tgt_data[0] = 32'h0BAD_CAFE;
        tgt_data[1] = 32'h1234_5678;
        tgt_data[2] = 32'hA5A5_0002;
        tgt_data[3] = 32'hCAFE_F00D;
        tgt_wait[0] = 1;
        tgt_wait[1] = 3;
        tgt_wait[2] = 0;
        tgt_wait[3] = 2;
        repeat (3) @(negedge pclk);
        check_all_zero("reset");
        preset = 1'b0;

        // Write to target 2, zero wait states
        xfer(32'h0000_2010, 1'b1, 32'hDEAD_BEEF, 4'hF, 4'b0100, 32'hA5A5_0002, 1'b0, 3, 1'b0, 1'b0);
        // Read target 1, three wait states
        xfer(32'h0000_1004, 1'b0, 32'h0, 4'h0, 4'b0010, 32'h1234_5678, 1'b0, 6, 1'b0, 1'b0);
        // Unmapped regions 4..7
        xfer(32'h0000_5000, 1'b0, 32'h0, 4'h0, 4'b0000, 32'h0, 1'b1, 1, 1'b0, 1'b0);
        xfer(32'h0000_4FFC, 1'b1, 32'h1, 4'h1, 4'b0000, 32'h0, 1'b1, 1, 1'b0, 1'b0);
        xfer(32'h0000_7FFC, 1'b0, 32'h0, 4'h0, 4'b0000, 32'h0, 1'b1, 1, 1'b0, 1'b0);
        // Target 3 error while idle target 0 asserts ready/error
        xfer(32'h0000_3000, 1'b0, 32'h0, 4'h0, 4'b1000, 32'hCAFE_F00D, 1'b1, 5, 1'b0, 1'b0);
        // Target 0, one wait state
        xfer(32'h0000_0008, 1'b0, 32'h0, 4'h0, 4'b0001, 32'h0BAD_CAFE, 1'b0, 4, 1'b0, 1'b0);
        // Back-to-back with s_psel held high through RESP
        xfer(32'h0000_2000, 1'b1, 32'h1111_2222, 4'h3, 4'b0100, 32'hA5A5_0002, 1'b0, 3, 1'b1, 1'b0);
        xfer(32'h0000_1008, 1'b0, 32'h0, 4'h0, 4'b0010, 32'h1234_5678, 1'b0, 7, 1'b0, 1'b0);

`ifdef BFORGE_APB_SPLITTER_TIMEOUT_EN
        tgt_wait[0] = 1000;
        xfer(32'h0000_0010, 1'b0, 32'h0, 4'h0, 4'b0001, 32'h0, 1'b1, 18, 1'b0, 1'b1);
        tgt_wait[0] = 15;
        xfer(32'h0000_0014, 1'b0, 32'h0, 4'h0, 4'b0001, 32'h0BAD_CAFE, 1'b0, 18, 1'b0, 1'b0);
        tgt_wait[0] = 14;
        xfer(32'h0000_0018, 1'b0, 32'h0, 4'h0, 4'b0001, 32'h0BAD_CAFE, 1'b0, 17, 1'b0, 1'b0);
`else
        tgt_wait[0] = 20;
        xfer(32'h0000_0010, 1'b0, 32'h0, 4'h0, 4'b0001, 32'h0BAD_CAFE, 1'b0, 23, 1'b0, 1'b0);
`endif

        // Reset during ACCESS of a target 3 write
        tgt_wait[3] = 50;
        s_paddr  = 32'h0000_3010;
        s_pwrite = 1'b1;
        s_pwdata = 32'h55AA_55AA;
        s_pstrb  = 4'hC;
        s_pprot  = 3'h4;
        s_psel   = 1'b1;
        req_q.push_back('{sel: 4'b1000, addr: 32'h0000_3010, wr: 1'b1, wdata: 32'h55AA_55AA,
                          strb: 4'hC, prot: 3'h4});
        @(negedge pclk);
        s_psel = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (m_penable) break;
            @(negedge pclk);
        end
        chk("rst_reached_access", 64'(m_penable), 64'd1);
        @(negedge pclk);
        preset = 1'b1;
        @(negedge pclk);
        check_all_zero("midreset");
        tgt_wait[3] = 2;
        preset = 1'b0;
        // First transfer sampled in the cycle right after reset release
        xfer(32'h0000_2004, 1'b0, 32'h0, 4'h0, 4'b0100, 32'hA5A5_0002, 1'b0, 3, 1'b0, 1'b0);

        repeat (3) @(negedge pclk);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        chk("req_queue_drained", 64'(req_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bforge_apb_splitter.md
BFORGE_APB_SPLITTER -- requirements
Module: bforge_apb_splitter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (8/16/32).
REQ-003 SHALL have parameter SEL_LSB, default 12, LSB of the 3-bit region field paddr[SEL_LSB+2:SEL_LSB].
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, range 2..255, ACCESS-cycle limit.
REQ-005 pclk  in  1  sole clock, all state on rising edge.
REQ-006 preset  in  1  synchronous, active-high reset.
REQ-007 s_paddr/s_pwrite/s_pwdata/s_pstrb/s_pprot  in  ADDR_W/1/DATA_W/DATA_W/8/3  upstream request.
REQ-008 s_psel, s_penable  in  1 each  upstream APB control.
REQ-009 s_prdata  out  DATA_W; s_pready  out  1; s_pslverr  out  1  upstream response.
REQ-010 m_paddr/m_pwrite/m_pwdata/m_pstrb/m_pprot  out  same widths  registered request broadcast to all targets.
REQ-011 m_psel  out  4  one-hot target select; m_penable  out  1.
REQ-012 m_prdata  in  4*DATA_W (target i at [i*DATA_W +: DATA_W]); m_pready  in  4; m_pslverr  in  4.
REQ-013 timeout_o  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, ACCESS, RESP.
REQ-015 IDLE: on s_psel=1, SHALL capture request fields and region, go SETUP if region 0..3, else go RESP with error.
REQ-016 SETUP: SHALL drive m_psel[region]=1, m_penable=0; next state ACCESS unconditionally.
REQ-017 ACCESS: SHALL drive m_psel[region]=1, m_penable=1; on m_pready[region]=1 capture m_prdata slice and m_pslverr[region], go RESP.
REQ-018 RESP: SHALL drive s_pready=1 for exactly one cycle with captured s_prdata/s_pslverr; next state IDLE.
REQ-019 s_pready SHALL be 0 in every state except RESP; s_prdata/s_pslverr SHALL be 0 outside RESP.
REQ-020 m_* request outputs SHALL hold captured values from SETUP through ACCESS; m_psel/m_penable SHALL be 0 in IDLE and RESP.
REQ-021 Latency: target with zero wait states SHALL yield s_pready in the 3rd cycle after the cycle s_psel is sampled in IDLE; each target wait state adds one cycle.
REQ-022 Regions 4..7 SHALL produce RESP with s_pslverr=1, s_prdata=0, and no m_psel assertion.
REQ-023 m_pready/m_pslverr of non-selected targets SHALL be ignored.
REQ-024 s_psel deasserting during SETUP/ACCESS SHALL be ignored; the downstream transfer completes.
REQ-025 s_psel still high in RESP SHALL NOT start a new capture; the next transfer is sampled in IDLE at the earliest.
REQ-026 Back-to-back transfers SHALL have one IDLE cycle minimum between RESP and next SETUP.

Reset
REQ-027 preset=1 at any clock edge SHALL force IDLE, clear the watchdog counter, and drive all outputs to 0, including mid-transfer.
REQ-028 First transfer SHALL be sampled in the cycle after preset deasserts.

Configuration
REQ-029 Macro BFORGE_APB_SPLITTER_TIMEOUT_EN SHALL compile the watchdog in.
REQ-030 Defined: 8-bit counter cleared on entering ACCESS, incremented per ACCESS cycle without m_pready; reaching TIMEOUT_CYCLES SHALL drop m_psel/m_penable, pulse timeout_o, go RESP with s_pslverr=1, s_prdata=0.
REQ-031 Defined: m_pready in the same cycle the count reaches the limit SHALL win (normal completion, no timeout_o).
REQ-032 Undefined: no counter; ACCESS waits indefinitely; timeout_o SHALL be tied 0.

Verification
REQ-033 Write 0x0000_2010 data 0xDEADBEEF, target2 zero-wait -> m_psel=4'b0100, m_pwdata=0xDEADBEEF, s_pready in cycle 3, s_pslverr=0.
REQ-034 Read 0x0000_1004, target1 3 wait states returns 0x12345678 -> s_prdata=0x12345678 in cycle 6.
REQ-035 Read 0x0000_5000 -> no m_psel, s_pready cycle 1 after sample, s_pslverr=1, s_prdata=0.
REQ-036 TIMEOUT_EN, TIMEOUT_CYCLES=16, target0 never ready -> timeout_o pulse after 16 ACCESS cycles, s_pslverr=1.
REQ-037 preset asserted in ACCESS of a target3 write -> next cycle all outputs 0, state IDLE, no s_pready.
REQ-038 Target3 returns m_pslverr=1 with target0 m_pready=1 concurrently -> s_pslverr=1, timing set by target3 only.
